// File: rtl/timer_pkg.sv
// Shared definitions for the BCD up/down timers:
// state encoding and BCD digit width.
package timer_pkg;

  localparam int DIG_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_MAXED = 2'd3
  } state_t;

endpackage

// File: rtl/bcd_up_digit.sv
// One BCD up-counting digit with terminal value MAX.
// Chained through carry to form a multi-digit counter.
module bcd_up_digit
  import timer_pkg::*;
#(
  parameter int MAX = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [DIG_W-1:0] digit,
  output logic             carry
);

  localparam logic [DIG_W-1:0] LAST = DIG_W'(MAX);

  assign carry = inc & (digit == LAST);

  // Digit register: clear wins, else wrap or step on inc
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit <= '0;
    end else if (clr) begin
      digit <= '0;
    end else if (inc) begin
      digit <= carry ? '0 : digit + DIG_W'(1);
    end
  end

endmodule

// File: rtl/sw_upcount3.sv
// 3-digit BCD up-counting stopwatch with
// run/pause, clear and lap-freeze controls.
module sw_upcount3
  import timer_pkg::*;
#(
  parameter int CLK_DIV     = 50000000,
  parameter int DIG1_MAX    = 9,
  parameter int DIG2_MAX    = 9,
  parameter int DIG3_MAX    = 9,
  parameter int STOP_AT_MAX = 1
) (
  input  logic             CLK_I,
  input  logic             SW_RESET_I,
  input  logic             START_STOP_I,
  input  logic             CLEAR_I,
  input  logic             LAP_I,
  output logic [DIG_W-1:0] TIM_1,
  output logic [DIG_W-1:0] TIM_2,
  output logic [DIG_W-1:0] TIM_3,
  output logic             carry_1,
  output logic             carry_2,
  output logic             carry_3,
  output logic             pulse_1sec,
  output logic             RUNNING,
  output logic             MAXED,
  output logic             LAP_ACTIVE
);

  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
  localparam logic STOP = (STOP_AT_MAX != 0);

  state_t state, state_nx;

  logic [PW-1:0] presc;
  logic ss_q, lap_q;
  logic ss_rise, lap_rise;
  logic tick, at_last;
  logic c1, c2, c3;
  logic lap_act;
  logic [DIG_W-1:0] d1, d2, d3;
  logic [DIG_W-1:0] s1, s2, s3;

  assign ss_rise  = START_STOP_I & ~ss_q;
  assign lap_rise = LAP_I & ~lap_q;
  assign tick     = (state == ST_RUN) &&
                    (presc == PRE_LAST);

  // The tick about to land reaches the terminal value
  assign at_last = (d3 == DIG_W'(DIG3_MAX)) &&
                   (d2 == DIG_W'(DIG2_MAX)) &&
                   (d1 == DIG_W'(DIG1_MAX - 1));

  // Switch edge-detect registers
  always_ff @(posedge CLK_I or posedge SW_RESET_I) begin
    if (SW_RESET_I) begin
      ss_q  <= 1'b0;
      lap_q <= 1'b0;
    end else begin
      ss_q  <= START_STOP_I;
      lap_q <= LAP_I;
    end
  end

  // State register
  always_ff @(posedge CLK_I or posedge SW_RESET_I) begin
    if (SW_RESET_I) state <= ST_IDLE;
    else            state <= state_nx;
  end

  // Next state: clear first, then the tick, then the switch
  always_comb begin
    state_nx = state;
    if (CLEAR_I) begin
      state_nx = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (ss_rise) state_nx = ST_RUN;
        end
        ST_RUN: begin
          if (tick && at_last && STOP)
            state_nx = ST_MAXED;
          else if (ss_rise)
            state_nx = ST_PAUSE;
        end
        ST_PAUSE: begin
          if (ss_rise) state_nx = ST_RUN;
        end
        ST_MAXED: state_nx = ST_MAXED;
        default:  state_nx = ST_IDLE;
      endcase
    end
  end

  // Prescaler: zero in IDLE, frozen in PAUSE
  always_ff @(posedge CLK_I or posedge SW_RESET_I) begin
    if (SW_RESET_I) begin
      presc <= '0;
    end else if (CLEAR_I || state == ST_IDLE) begin
      presc <= '0;
    end else if (state == ST_RUN) begin
      presc <= tick ? '0 : presc + PW'(1);
    end
  end

  // Lap snapshot: take pre-tick digits, toggle off on next rise
  always_ff @(posedge CLK_I or posedge SW_RESET_I) begin
    if (SW_RESET_I) begin
      lap_act <= 1'b0;
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else if (CLEAR_I) begin
      lap_act <= 1'b0;
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else if (lap_rise) begin
      if (lap_act) begin
        lap_act <= 1'b0;
      end else if (state == ST_RUN ||
                   state == ST_PAUSE) begin
        lap_act <= 1'b1;
        s1 <= d1;
        s2 <= d2;
        s3 <= d3;
      end
    end
  end

  bcd_up_digit #(.MAX(DIG1_MAX)) u_d1 (
    .clk   (CLK_I),
    .reset (SW_RESET_I),
    .clr   (CLEAR_I),
    .inc   (tick),
    .digit (d1),
    .carry (c1)
  );

  bcd_up_digit #(.MAX(DIG2_MAX)) u_d2 (
    .clk   (CLK_I),
    .reset (SW_RESET_I),
    .clr   (CLEAR_I),
    .inc   (c1),
    .digit (d2),
    .carry (c2)
  );

  bcd_up_digit #(.MAX(DIG3_MAX)) u_d3 (
    .clk   (CLK_I),
    .reset (SW_RESET_I),
    .clr   (CLEAR_I),
    .inc   (c2),
    .digit (d3),
    .carry (c3)
  );

  assign TIM_1      = lap_act ? s1 : d1;
  assign TIM_2      = lap_act ? s2 : d2;
  assign TIM_3      = lap_act ? s3 : d3;
  assign carry_1    = c1;
  assign carry_2    = c2;
  assign carry_3    = c3;
  assign pulse_1sec = tick;
  assign RUNNING    = (state == ST_RUN);
  assign MAXED      = (state == ST_MAXED);
  assign LAP_ACTIVE = lap_act;

endmodule

// File: tb/tb_sw_upcount3.sv
// Directed bench for sw_upcount3 across four
// parameter sets driven from shared switch inputs.
module tb_sw_upcount3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ss  = 1'b0;
  logic clr = 1'b0;
  logic lap = 1'b0;

  always #5 clk = ~clk;

  // a: 999 stop; b: 959 wrap; c: 111 stop; d: 111 wrap
  logic [3:0] a1, a2, a3, b1, b2, b3;
  logic [3:0] c1, c2, c3, e1, e2, e3;
  logic a_c1, a_c2, a_c3, a_p, a_r, a_m, a_l;
  logic b_c1, b_c2, b_c3, b_p, b_r, b_m, b_l;
  logic c_c1, c_c2, c_c3, c_p, c_r, c_m, c_l;
  logic d_c1, d_c2, d_c3, d_p, d_r, d_m, d_l;

  sw_upcount3 #(.CLK_DIV(4)) dut_a (
    .CLK_I(clk), .SW_RESET_I(rst),
    .START_STOP_I(ss), .CLEAR_I(clr), .LAP_I(lap),
    .TIM_1(a1), .TIM_2(a2), .TIM_3(a3),
    .carry_1(a_c1), .carry_2(a_c2), .carry_3(a_c3),
    .pulse_1sec(a_p), .RUNNING(a_r),
    .MAXED(a_m), .LAP_ACTIVE(a_l)
  );

  sw_upcount3 #(
    .CLK_DIV(4), .DIG2_MAX(5), .STOP_AT_MAX(0)
  ) dut_b (
    .CLK_I(clk), .SW_RESET_I(rst),
    .START_STOP_I(ss), .CLEAR_I(clr), .LAP_I(lap),
    .TIM_1(b1), .TIM_2(b2), .TIM_3(b3),
    .carry_1(b_c1), .carry_2(b_c2), .carry_3(b_c3),
    .pulse_1sec(b_p), .RUNNING(b_r),
    .MAXED(b_m), .LAP_ACTIVE(b_l)
  );

  sw_upcount3 #(
    .CLK_DIV(4), .DIG1_MAX(1), .DIG2_MAX(1),
    .DIG3_MAX(1), .STOP_AT_MAX(1)
  ) dut_c (
    .CLK_I(clk), .SW_RESET_I(rst),
    .START_STOP_I(ss), .CLEAR_I(clr), .LAP_I(lap),
    .TIM_1(c1), .TIM_2(c2), .TIM_3(c3),
    .carry_1(c_c1), .carry_2(c_c2), .carry_3(c_c3),
    .pulse_1sec(c_p), .RUNNING(c_r),
    .MAXED(c_m), .LAP_ACTIVE(c_l)
  );

  sw_upcount3 #(
    .CLK_DIV(4), .DIG1_MAX(1), .DIG2_MAX(1),
    .DIG3_MAX(1), .STOP_AT_MAX(0)
  ) dut_d (
    .CLK_I(clk), .SW_RESET_I(rst),
    .START_STOP_I(ss), .CLEAR_I(clr), .LAP_I(lap),
    .TIM_1(e1), .TIM_2(e2), .TIM_3(e3),
    .carry_1(d_c1), .carry_2(d_c2), .carry_3(d_c3),
    .pulse_1sec(d_p), .RUNNING(d_r),
    .MAXED(d_m), .LAP_ACTIVE(d_l)
  );

  wire [11:0] a_cnt = {a3, a2, a1};
  wire [11:0] b_cnt = {b3, b2, b1};
  wire [11:0] c_cnt = {c3, c2, c1};
  wire [11:0] d_cnt = {e3, e2, e1};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    int         k;
    logic [11:0] a_cnt;
    logic        a_pul;
    logic        a_c1;
    logic [11:0] b_cnt;
    logic [11:0] c_cnt;
    logic        c_max;
    logic        c_pul;
    logic [11:0] d_cnt;
    logic        d_c3;
  } vec_t;

  vec_t tbl[9];
  int   cur;

  initial begin
    // k = clock edges since the start rise was seen
    tbl[0] = '{1,  12'h000,1'b0,1'b0,12'h000,
               12'h000,1'b0,1'b0,12'h000,1'b0};
    tbl[1] = '{4,  12'h000,1'b1,1'b0,12'h000,
               12'h000,1'b0,1'b1,12'h000,1'b0};
    tbl[2] = '{5,  12'h001,1'b0,1'b0,12'h001,
               12'h001,1'b0,1'b0,12'h001,1'b0};
    tbl[3] = '{28, 12'h006,1'b1,1'b0,12'h006,
               12'h110,1'b0,1'b1,12'h110,1'b0};
    tbl[4] = '{29, 12'h007,1'b0,1'b0,12'h007,
               12'h111,1'b1,1'b0,12'h111,1'b0};
    tbl[5] = '{32, 12'h007,1'b1,1'b0,12'h007,
               12'h111,1'b1,1'b0,12'h111,1'b1};
    tbl[6] = '{33, 12'h008,1'b0,1'b0,12'h008,
               12'h111,1'b1,1'b0,12'h000,1'b0};
    tbl[7] = '{40, 12'h009,1'b1,1'b1,12'h009,
               12'h111,1'b1,1'b0,12'h001,1'b0};
    tbl[8] = '{41, 12'h010,1'b0,1'b0,12'h010,
               12'h111,1'b1,1'b0,12'h010,1'b0};

    // Power-on reset
    #2 rst = 1'b1;
    #1;
    chk("rst_cnt", a_cnt, 0);
    chk("rst_flags", {a_p, a_r, a_m, a_l, a_c1}, 0);
    #10 rst = 1'b0;
    step(1);

    // Start and walk the table
    ss = 1'b1;
    step(1);
    cur = 1;
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].k - cur);
      cur = tbl[i].k;
      chk($sformatf("a_cnt@%0d", cur), a_cnt, tbl[i].a_cnt);
      chk($sformatf("a_pul@%0d", cur), a_p, tbl[i].a_pul);
      chk($sformatf("a_c1@%0d", cur), a_c1, tbl[i].a_c1);
      chk($sformatf("b_cnt@%0d", cur), b_cnt, tbl[i].b_cnt);
      chk($sformatf("c_cnt@%0d", cur), c_cnt, tbl[i].c_cnt);
      chk($sformatf("c_max@%0d", cur), c_m, tbl[i].c_max);
      chk($sformatf("c_pul@%0d", cur), c_p, tbl[i].c_pul);
      chk($sformatf("d_cnt@%0d", cur), d_cnt, tbl[i].d_cnt);
      chk($sformatf("d_c3@%0d", cur), d_c3, tbl[i].d_c3);
    end
    chk("a_run", a_r, 1);

    // 059 -> 100 on the seconds-style counter
    step(240 - cur);
    chk("b_059", b_cnt, 12'h059);
    chk("b_carries", {b_c3, b_c2, b_c1}, 3'b011);
    chk("a_carries", {a_c3, a_c2, a_c1}, 3'b001);
    chk("d_cnt240", d_cnt, 12'h011);
    step(1);
    chk("b_100", b_cnt, 12'h100);
    chk("a_060", a_cnt, 12'h060);
    chk("d_cnt241", d_cnt, 12'h100);

    // MAXED ignores start/stop; a pauses
    ss = 1'b0; step(1);
    ss = 1'b1; step(1);
    chk("c_max_hold", c_m, 1);
    chk("c_cnt_hold", c_cnt, 12'h111);
    chk("a_paused", a_r, 0);
    ss = 1'b0; step(1);
    ss = 1'b1; step(1);
    chk("a_resumed", a_r, 1);
    ss = 1'b0; step(1);

    // Clear beats a same-cycle start/stop rise
    clr = 1'b1; ss = 1'b1;
    step(1);
    chk("clr_run", a_r, 0);
    chk("clr_cnt", a_cnt, 0);
    chk("clr_cmax", c_m, 0);
    chk("clr_ccnt", c_cnt, 0);
    chk("clr_dcnt", d_cnt, 0);
    clr = 1'b0; ss = 1'b0;
    step(1);
    chk("idle_run", a_r, 0);

    // Pause in the third second, then resume
    ss = 1'b1; step(1);
    ss = 1'b0; step(9);
    chk("pz_cnt", a_cnt, 12'h002);
    chk("pz_pul", a_p, 0);
    ss = 1'b1; step(1);
    chk("pz_paused", a_r, 0);
    ss = 1'b0; step(5);
    chk("pz_hold", a_cnt, 12'h002);
    chk("pz_nopul", a_p, 0);
    ss = 1'b1; step(1);
    chk("rs_run", a_r, 1);
    chk("rs_pul0", a_p, 0);
    ss = 1'b0; step(1);
    chk("rs_pul1", a_p, 1);
    step(1);
    chk("rs_cnt", a_cnt, 12'h003);

    // Lap freeze at 005 while live count reaches 008
    step(8);
    chk("lap_pre", a_cnt, 12'h005);
    lap = 1'b1; step(1);
    chk("lap_on", a_l, 1);
    chk("lap_tim", a_cnt, 12'h005);
    lap = 1'b0; step(11);
    chk("lap_frozen", a_cnt, 12'h005);
    lap = 1'b1; step(1);
    chk("lap_off", a_l, 0);
    chk("lap_live", a_cnt, 12'h008);
    lap = 1'b0;

    // Asynchronous reset at 003
    clr = 1'b1; step(1);
    clr = 1'b0;
    ss = 1'b1; step(1);
    ss = 1'b0; step(12);
    chk("mr_cnt", a_cnt, 12'h003);
    #2 rst = 1'b1;
    #1;
    chk("mr_async_cnt", a_cnt, 0);
    chk("mr_async_run", a_r, 0);
    #2 rst = 1'b0;
    step(2);
    chk("mr_idle", a_r, 0);
    chk("mr_cnt0", a_cnt, 0);
    chk("mr_cmax", c_m, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/sw_upcount3.md
Name: sw_upcount3

Overview:
- 3-digit BCD up-counting stopwatch. It is the count-up counterpart of the team's 3-digit down-counting countdown timer.
- It generates its own 1-second tick from CLK_I and counts elapsed seconds from 000 upward.
- Run, pause, clear and lap-freeze are controlled from debounced front-panel switches.
- Outputs feed the existing 7-segment display mux digit-for-digit, using the same TIM_n and carry-chain style as the countdown timer.

Parameters:
- CLK_DIV, 50000000, CLK_I cycles per count tick (must be 2 or more).
- DIG1_MAX, 9, terminal value of the ones digit (1..9).
- DIG2_MAX, 9, terminal value of the tens digit (1..9); 5 gives seconds-style 0..59.
- DIG3_MAX, 9, terminal value of the hundreds digit (1..9).
- STOP_AT_MAX, 1, 1 = halt at the all-terminal value; 0 = wrap to 000 and keep running.

Ports:
- CLK_I, in, 1, system clock.
- SW_RESET_I, in, 1, asynchronous active-high reset.
- START_STOP_I, in, 1, debounced level; each rising edge toggles run/pause.
- CLEAR_I, in, 1, debounced level; while high, forces count to 000 and state to IDLE.
- LAP_I, in, 1, debounced level; each rising edge toggles the display freeze.
- TIM_1, out, 4, displayed ones digit (BCD).
- TIM_2, out, 4, displayed tens digit.
- TIM_3, out, 4, displayed hundreds digit.
- carry_1, out, 1, one-cycle pulse when the ones digit wraps.
- carry_2, out, 1, one-cycle pulse when the tens digit wraps.
- carry_3, out, 1, one-cycle pulse when the hundreds digit wraps.
- pulse_1sec, out, 1, one-cycle tick strobe; asserted only in RUN.
- RUNNING, out, 1, high in RUN.
- MAXED, out, 1, high in MAXED.
- LAP_ACTIVE, out, 1, high while the display is frozen.

Behaviour:
- **Reset** (asynchronous, takes effect immediately):
  - state = IDLE; prescaler, internal digits and lap snapshot = 0.
  - Edge-detect registers = 0.
  - All outputs = 0.
- **Edge detect:** each switch input is registered once. rise = input & ~input_q. The state reacts on the clock edge after the rise is seen.
- **States:** IDLE, RUN, PAUSE, MAXED.
  - IDLE to RUN on a START_STOP rise. Prescaler is cleared, so the first tick comes exactly CLK_DIV cycles after entering RUN.
  - RUN to PAUSE on a START_STOP rise. Prescaler holds its value; on resume the remaining fraction of the second is preserved.
  - PAUSE to RUN on a START_STOP rise.
  - RUN to MAXED when a tick makes the count equal DIG3_MAX,DIG2_MAX,DIG1_MAX, only if STOP_AT_MAX = 1.
  - MAXED ignores START_STOP.
  - CLEAR_I high from any state: go to IDLE, digits = 0, prescaler = 0, lap released. CLEAR has priority over a simultaneous START_STOP or LAP rise.
- **Prescaler:** counts 0..CLK_DIV-1 in RUN only. tick = RUN & (prescaler == CLK_DIV-1). pulse_1sec = tick, driven combinationally from registered state.
- **Count update:** digits update on the tick edge and are visible in the cycle after pulse_1sec.
  - carry_1 = tick & (d1 == DIG1_MAX).
  - carry_2 = carry_1 & (d2 == DIG2_MAX).
  - carry_3 = carry_2 & (d3 == DIG3_MAX).
  - A digit wraps to 0 on its own carry and increments when the lower carry (or tick, for the ones digit) is high.
  - Carries are combinational and coincident with pulse_1sec.
  - STOP_AT_MAX = 0: 999 (or the terminal value) goes to 000 with carry_3 pulsing, and RUN continues.
  - STOP_AT_MAX = 1: carry_3 never fires.
- **Lap:**
  - A LAP rise while LAP_ACTIVE = 0 in RUN or PAUSE copies the current digits into the snapshot and sets LAP_ACTIVE.
  - A LAP rise while LAP_ACTIVE = 1 clears LAP_ACTIVE.
  - A LAP rise in IDLE or MAXED is ignored.
  - TIM_n = LAP_ACTIVE ? snapshot : live digits. Counting continues underneath.
- **Same-cycle events:**
  - A START_STOP rise on a tick cycle: the tick is applied, then the state changes.
  - A LAP rise on a tick cycle: the snapshot takes the pre-increment value.
- **Widths:** digits are 4-bit and never exceed their MAX. Prescaler width = $clog2(CLK_DIV).

Decomposition:
- Shared package (timer_pkg): state encoding localparams (ST_IDLE = 0, ST_RUN = 1, ST_PAUSE = 2, ST_MAXED = 3) and the BCD digit width constant (4). The countdown timer uses the same package.
- One natural sub-module: bcd_up_digit (parameter MAX). Inputs clk, reset, clr, inc; outputs digit and carry. Instantiated three times in a chain.

Test Plan:
All scenarios use CLK_DIV = 4 unless stated.
1. Reset mid-run: assert SW_RESET_I between clock edges while the count reads 003. All outputs go to 0 before the next edge; after release the state is IDLE.
2. START_STOP rise, then 40 cycles: pulse_1sec fires at cycles 4, 8, …, 40. The count reads 010, carry_1 pulses with the 10th tick, RUNNING = 1.
3. DIG2_MAX = 5: run to 059, then one more tick gives 100. carry_1 and carry_2 are high in the same cycle; carry_3 stays 0.
4. All MAX = 1, STOP_AT_MAX = 1: the 7th tick gives 111 and MAXED = 1, with no further pulse_1sec. A START_STOP rise is ignored; CLEAR_I gives 000 and IDLE.
5. Pause and lap: pause after 2 cycles of the third second, resume, and the next tick comes 2 cycles later. A LAP rise at 005 freezes TIM at 005 while the live count reaches 008; a second LAP rise shows 008.
6. CLEAR_I and a START_STOP rise in the same cycle from RUN: the result is IDLE, 000, RUNNING = 0.
